// File: rtl/kgp_control_fsm.sv
// kgp_control_fsm
//   Multicycle controller for the KGP-RISC core. Accepts one instruction
//   word at a time over a valid/ready handshake. It owns PC and NPC and
//   sequences FETCH -> DECODE -> EXEC -> [MEM] -> WB. It drives every
//   DataPath control input. Branches are evaluated against a flag register
//   that is loaded at the end of EXEC by R- and I-type instructions.
//
//   Optional feature macro: KGP_ILLEGAL_TRAP_EN
//     defined   : opcode 110 halts the core (halted=1).
//     undefined : opcode 110 runs as a NOP (no strobes, pc advances).
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   instr, instr_valid / instr_ready   instruction handshake
//   zero/carry/sign/overflow_flag      ALU flags, sampled only in EXEC
//   pc, npc                            current / next fetch address
//   regAddr_1, regAddr_2, shift_amount, immediate_const, alu_control
//                                      decoded fields, valid DECODE..WB
//   ALU_src, const_src, reg_data, regWrite_select, reg_to_pc
//                                      DataPath mux selects
//   MemRead, MemWrite, regWriteEnable  memory / register-file strobes
//   halted                             sticky until rst
module kgp_control_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        zero_flag,
  input  logic        carry_flag,
  input  logic        sign_flag,
  input  logic        overflow_flag,
  output logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [4:0]  regAddr_1,
  output logic [4:0]  regAddr_2,
  output logic [4:0]  shift_amount,
  output logic [20:0] immediate_const,
  output logic [3:0]  alu_control,
  output logic        ALU_src,
  output logic        const_src,
  output logic        reg_data,
  output logic        regWrite_select,
  output logic        reg_to_pc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        regWriteEnable,
  output logic        halted
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_I    = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BR   = 3'b100;
  localparam logic [2:0] OP_JR   = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  // Latched ALU flags: {Z, C, S, V}
  logic [3:0]  flags_q, flags_d;

  logic [2:0]  op;
  logic        accept;
  logic        cond_true;
  logic        in_instr;

  assign op     = ir_q[31:29];
  assign accept = (state_q == S_FETCH) && instr_valid;

  // Branch condition uses the flag register, never the live flag inputs.
  always_comb begin
    cond_true = 1'b0;
    case (ir_q[28:26])
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = flags_q[3];
      3'd2:    cond_true = !flags_q[3];
      3'd3:    cond_true = flags_q[2];
      3'd4:    cond_true = !flags_q[2];
      3'd5:    cond_true = flags_q[1];
      3'd6:    cond_true = !flags_q[1];
      default: cond_true = flags_q[0];
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      ir_q    <= 32'd0;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + STEP;
      flags_q <= 4'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      flags_q <= flags_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (accept) state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
`ifdef KGP_ILLEGAL_TRAP_EN
        if (op == 3'b110) state_d = S_HALT;
`endif
      end
      S_EXEC:   state_d = (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
      S_MEM:    state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RESET;
    endcase
  end

  // Next values of IR, PC, NPC and the flag register.
  always_comb begin
    ir_d    = ir_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    flags_d = flags_q;
    case (state_q)
      S_FETCH: begin
        if (accept) begin
          ir_d  = instr;
          npc_d = pc_q + STEP;
        end
      end
      S_EXEC: begin
        if (op == OP_R || op == OP_I) begin
          flags_d = {zero_flag, carry_flag, sign_flag, overflow_flag};
        end
        if (op == OP_BR && cond_true) begin
          npc_d = {4'b0000, ir_q[25:0], 2'b00};
        end
      end
      S_WB: begin
        // For JR the DataPath substitutes rs for npc via reg_to_pc;
        // the controller has no view of register contents.
        pc_d  = npc_q;
        npc_d = npc_q + STEP;
      end
      default: ;
    endcase
  end

  assign in_instr = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                    (state_q == S_MEM)    || (state_q == S_WB);

  // Output logic. Decoded fields are held from DECODE until the next FETCH.
  always_comb begin
    instr_ready     = (state_q == S_FETCH);
    halted          = (state_q == S_HALT);
    pc              = pc_q;
    npc             = npc_q;
    regAddr_1       = 5'd0;
    regAddr_2       = 5'd0;
    shift_amount    = 5'd0;
    immediate_const = 21'd0;
    alu_control     = 4'd0;
    ALU_src         = 1'b0;
    const_src       = 1'b0;
    reg_data        = 1'b0;
    regWrite_select = 1'b0;
    reg_to_pc       = 1'b0;
    MemRead         = 1'b0;
    MemWrite        = 1'b0;
    regWriteEnable  = 1'b0;
    if (in_instr) begin
      case (op)
        OP_R: begin
          regAddr_1       = ir_q[28:24];
          regAddr_2       = ir_q[23:19];
          shift_amount    = ir_q[18:14];
          alu_control     = ir_q[3:0];
          const_src       = (ir_q[3:0] >= 4'd8) && (ir_q[3:0] <= 4'd10);
          regWrite_select = 1'b1;
        end
        OP_I: begin
          // Two-operand form: rs is both source and destination.
          regAddr_1       = ir_q[28:24];
          regAddr_2       = ir_q[28:24];
          alu_control     = {1'b0, ir_q[23:21]};
          immediate_const = ir_q[20:0];
          ALU_src         = 1'b1;
          regWrite_select = 1'b1;
        end
        OP_LW: begin
          regAddr_1       = ir_q[28:24];
          regAddr_2       = ir_q[23:19];
          immediate_const = {2'b00, ir_q[18:0]};
          ALU_src         = 1'b1;
          reg_data        = 1'b1;
          regWrite_select = 1'b1;
          MemRead         = (state_q == S_MEM) || (state_q == S_WB);
        end
        OP_SW: begin
          regAddr_1       = ir_q[28:24];
          regAddr_2       = ir_q[23:19];
          immediate_const = {2'b00, ir_q[18:0]};
          ALU_src         = 1'b1;
          MemWrite        = (state_q == S_MEM) && !rst;
        end
        OP_JR: begin
          regAddr_1       = ir_q[28:24];
          regAddr_2       = 5'd31;
          reg_to_pc       = 1'b1;
          regWrite_select = 1'b0;
        end
        default: ;
      endcase
      // A reset arriving mid-instruction must not let a write escape.
      if (state_q == S_WB && !rst &&
          (op == OP_R || op == OP_I || op == OP_LW || op == OP_JR)) begin
        regWriteEnable = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kgp_control_fsm.sv
// Directed testbench for kgp_control_fsm. Drives hand-encoded instructions
// and compares outputs against hand-computed values.
module tb_kgp_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        zero_flag, carry_flag, sign_flag, overflow_flag;
  logic        instr_ready;
  logic [31:0] pc, npc;
  logic [4:0]  regAddr_1, regAddr_2, shift_amount;
  logic [20:0] immediate_const;
  logic [3:0]  alu_control;
  logic        ALU_src, const_src, reg_data, regWrite_select, reg_to_pc;
  logic        MemRead, MemWrite, regWriteEnable, halted;

  int n_total = 0;
  int n_bad   = 0;

  // Snapshot of decoded fields (taken in DECODE) and per-instruction stats.
  logic [4:0]  d_ra1, d_ra2, d_sh;
  logic [20:0] d_imm;
  logic [3:0]  d_alu;
  logic        d_alusrc, d_csrc, d_rdata, d_wsel, d_r2pc;
  logic [31:0] wb_npc;
  int lat, we_n, we_at, mr_n, mw_n;

  always #5 clk = ~clk;

  kgp_control_fsm dut (
    .clk             (clk),
    .rst             (rst),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .zero_flag       (zero_flag),
    .carry_flag      (carry_flag),
    .sign_flag       (sign_flag),
    .overflow_flag   (overflow_flag),
    .instr_ready     (instr_ready),
    .pc              (pc),
    .npc             (npc),
    .regAddr_1       (regAddr_1),
    .regAddr_2       (regAddr_2),
    .shift_amount    (shift_amount),
    .immediate_const (immediate_const),
    .alu_control     (alu_control),
    .ALU_src         (ALU_src),
    .const_src       (const_src),
    .reg_data        (reg_data),
    .regWrite_select (regWrite_select),
    .reg_to_pc       (reg_to_pc),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .regWriteEnable  (regWriteEnable),
    .halted          (halted)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] sh, input logic [3:0] fn);
    return {3'b000, rs, rt, sh, 10'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] rs, input logic [2:0] fn,
                                        input logic [20:0] imm);
    return {3'b001, rs, fn, imm};
  endfunction

  function automatic logic [31:0] enc_m(input logic [2:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [18:0] off);
    return {op, rs, rt, off};
  endfunction

  function automatic logic [31:0] enc_br(input logic [2:0] cnd, input logic [25:0] tgt);
    return {3'b100, cnd, tgt};
  endfunction

  // Issue one instruction from FETCH and run it until instr_ready returns
  // (bounded). lat counts cycles from the accept edge to the next FETCH.
  task automatic exec_instr(input logic [31:0] w);
    int cyc;
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    d_ra1 = regAddr_1;  d_ra2 = regAddr_2;  d_sh = shift_amount;
    d_imm = immediate_const;  d_alu = alu_control;  d_alusrc = ALU_src;
    d_csrc = const_src;  d_rdata = reg_data;  d_wsel = regWrite_select;
    d_r2pc = reg_to_pc;
    we_n = 0; we_at = 0; mr_n = 0; mw_n = 0; wb_npc = 32'hx;
    cyc = 1;
    while (!instr_ready && cyc <= 20) begin
      if (regWriteEnable) begin we_n++; we_at = cyc; end
      if (MemRead)  mr_n++;
      if (MemWrite) mw_n++;
      wb_npc = npc;
      tick();
      cyc++;
    end
    lat = cyc - 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; instr = 32'd0; instr_valid = 1'b0;
    zero_flag = 1'b0; carry_flag = 1'b0; sign_flag = 1'b0; overflow_flag = 1'b0;

    // Reset state
    tick();
    rst = 1'b0;
    check_val("rst_pc", pc, 32'h0);
    check_val("rst_npc", npc, 32'h4);
    check_val("rst_ready", 32'(instr_ready), 0);
    check_val("rst_we", 32'(regWriteEnable), 0);
    check_val("rst_mem", 32'({MemRead, MemWrite}), 0);
    check_val("rst_halted", 32'(halted), 0);
    tick();
    check_val("ready_after_rst", 32'(instr_ready), 1);

    // R add rs=12 rt=14
    exec_instr(enc_r(5'd12, 5'd14, 5'd0, 4'd0));
    check_val("add_ra1", 32'(d_ra1), 12);
    check_val("add_ra2", 32'(d_ra2), 14);
    check_val("add_alu", 32'(d_alu), 0);
    check_val("add_alusrc", 32'(d_alusrc), 0);
    check_val("add_wsel", 32'(d_wsel), 1);
    check_val("add_lat", 32'(lat), 3);
    check_val("add_we_n", 32'(we_n), 1);
    check_val("add_we_at", 32'(we_at), 3);
    check_val("add_pc", pc, 32'h4);

    // LW rs=20 rt=30 off=40
    exec_instr(enc_m(3'b010, 5'd20, 5'd30, 19'd40));
    check_val("lw_imm", 32'(d_imm), 40);
    check_val("lw_alusrc", 32'(d_alusrc), 1);
    check_val("lw_rdata", 32'(d_rdata), 1);
    check_val("lw_mr_n", 32'(mr_n), 2);
    check_val("lw_we_n", 32'(we_n), 1);
    check_val("lw_lat", 32'(lat), 4);
    check_val("lw_pc", pc, 32'h8);

    // SW
    exec_instr(enc_m(3'b011, 5'd1, 5'd2, 19'd5));
    check_val("sw_mw_n", 32'(mw_n), 1);
    check_val("sw_we_n", 32'(we_n), 0);
    check_val("sw_lat", 32'(lat), 4);
    check_val("sw_pc", pc, 32'hC);

    // Shift boundary: func 8 is a shift, func 11 is not
    exec_instr(enc_r(5'd1, 5'd2, 5'd7, 4'd8));
    check_val("sll_csrc", 32'(d_csrc), 1);
    check_val("sll_sh", 32'(d_sh), 7);
    exec_instr(enc_r(5'd1, 5'd2, 5'd7, 4'd11));
    check_val("f11_csrc", 32'(d_csrc), 0);
    check_val("f11_pc", pc, 32'h14);

    // I-type, full-width immediate
    exec_instr(enc_i(5'd3, 3'd5, 21'h1FFFFF));
    check_val("i_alu", 32'(d_alu), 5);
    check_val("i_imm", 32'(d_imm), 32'h1FFFFF);
    check_val("i_alusrc", 32'(d_alusrc), 1);
    check_val("i_we_n", 32'(we_n), 1);
    check_val("i_pc", pc, 32'h18);

    // Flag latch then taken branch; live zero_flag differs during BR
    zero_flag = 1'b1;
    exec_instr(enc_r(5'd4, 5'd4, 5'd0, 4'd1));
    zero_flag = 1'b0;
    exec_instr(enc_br(3'd1, 26'd6));
    check_val("brz_t_npc", wb_npc, 32'd24);
    check_val("brz_t_pc", pc, 32'd24);
    check_val("brz_t_we_n", 32'(we_n), 0);
    check_val("brz_t_lat", 32'(lat), 3);

    // Same branch with Z latched 0 -> falls through
    exec_instr(enc_r(5'd4, 5'd5, 5'd0, 4'd1));
    zero_flag = 1'b1;
    exec_instr(enc_br(3'd1, 26'd6));
    zero_flag = 1'b0;
    check_val("brz_nt_npc", wb_npc, 32'd32);
    check_val("brz_nt_pc", pc, 32'd32);

    // Unconditional branch
    exec_instr(enc_br(3'd0, 26'h100));
    check_val("bra_pc", pc, 32'h400);

    // JR with link
    exec_instr({3'b101, 5'd5, 24'd0});
    check_val("jr_r2pc", 32'(d_r2pc), 1);
    check_val("jr_wsel", 32'(d_wsel), 0);
    check_val("jr_ra2", 32'(d_ra2), 31);
    check_val("jr_we_n", 32'(we_n), 1);
    check_val("jr_pc", pc, 32'h404);

    // Illegal opcode
`ifdef KGP_ILLEGAL_TRAP_EN
    instr = {3'b110, 29'd0};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check_val("ill_halted", 32'(halted), 1);
    check_val("ill_ready", 32'(instr_ready), 0);
    do_reset();
`else
    exec_instr({3'b110, 29'd0});
    check_val("ill_lat", 32'(lat), 3);
    check_val("ill_strobes", 32'(we_n + mr_n + mw_n), 0);
    check_val("ill_pc", pc, 32'h408);
    check_val("ill_halted", 32'(halted), 0);
`endif

    // Reset arriving in the WB cycle of a LW
    instr = enc_m(3'b010, 5'd1, 5'd2, 19'd3);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check_val("rstlw_we", 32'(regWriteEnable), 0);
    check_val("rstlw_mw", 32'(MemWrite), 0);
    tick();
    rst = 1'b0;
    check_val("rstlw_pc", pc, 32'h0);
    check_val("rstlw_mr", 32'(MemRead), 0);
    tick();
    check_val("rstlw_ready", 32'(instr_ready), 1);

    // HALT is absorbing
    instr = {3'b111, 29'd0};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check_val("halt_halted", 32'(halted), 1);
    instr_valid = 1'b1;
    tick(); tick(); tick();
    instr_valid = 1'b0;
    check_val("halt_sticky", 32'(halted), 1);
    check_val("halt_ready", 32'(instr_ready), 0);
    check_val("halt_pc", pc, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
